multi_session: RTL and testbench
================================

MULTI_SESSION -- requirements
Module: multi_session

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of concurrent call channels (1..4).
REQ-002 SHALL have parameter ADDR_W, default 8, phone address width.
REQ-003 SHALL have parameter RING_TO, default 1000, outgoing-ring timeout in clk cycles.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port phoneNum  input  ADDR_W  dial target for CALL.
REQ-007 SHALL have port userInp  input  5  user command: 0x00 none, 0x01 CALL, 0x02 ANSWER, 0x03 HANGUP, 0x04 REJECT; one-cycle strobe.
REQ-008 SHALL have port userCh  input  clog2(N_CH)  channel targeted by userInp.
REQ-009 SHALL have port audioIn  input  16  local sample, taken when audioInFlag=1.
REQ-010 SHALL have port cmdIn  input  2  received packet type: 00 none, 01 control, 10 audio, 11 ignored; one-cycle strobe.
REQ-011 SHALL have port packetIn  input  16  control: [7:0] code (01 CALL_REQ, 02 ACCEPT, 03 REJECT/BUSY, 04 HANGUP); audio: sample.
REQ-012 SHALL have port srcIn  input  ADDR_W  sender address of the received packet.
REQ-013 SHALL have port transportBusy  input  1  transport cannot accept an offer this cycle.
REQ-014 SHALL have port audioInFlag  output  1  one-cycle pulse; audioIn sampled this cycle.
REQ-015 SHALL have port audioOutFlag  output  1  one-cycle pulse; audioOut updated.
REQ-016 SHALL have port audioOut  output  16  saturated mix of connected channels.
REQ-017 SHALL have port cmd, dataOut, phoneOut  output  2 / 16 / ADDR_W  transmit offer (cmd encoding as cmdIn; 00 = no offer), payload, destination.
REQ-018 SHALL have port sessionBusy  output  1  high when any channel is not IDLE.
REQ-019 SHALL have port current_state  output  3*N_CH  packed per-channel state, channel 0 in [2:0].

Function
REQ-020 Each channel SHALL run an FSM: IDLE=0, DIALING=1, RING_OUT=2, INCOMING=3, CONNECTED=4, plus a stored peer address.
REQ-021 CALL on an IDLE channel SHALL latch phoneNum as peer, enter DIALING, and queue CALL_REQ to peer; on transfer -> RING_OUT, ring counter cleared.
REQ-022 In RING_OUT: ACCEPT from peer -> CONNECTED; REJECT/BUSY from peer -> IDLE; counter reaching RING_TO-1 -> queue HANGUP to peer, then IDLE.
REQ-023 CALL_REQ received SHALL occupy the lowest-index IDLE channel (-> INCOMING, peer=srcIn); if none is IDLE, queue BUSY(03) to srcIn, no state change.
REQ-024 In INCOMING: ANSWER -> queue ACCEPT, CONNECTED; REJECT -> queue REJECT, IDLE; HANGUP from peer -> IDLE.
REQ-025 HANGUP by user in any non-IDLE state SHALL queue HANGUP to peer and -> IDLE; HANGUP received from peer SHALL -> IDLE with nothing sent.
REQ-026 Control packets from srcIn not matching any channel peer (except CALL_REQ) SHALL be ignored; user commands invalid for the current state or for userCh>=N_CH SHALL be ignored.
REQ-027 Received packet and user command on the same channel in the same cycle: packet processed, user command dropped.
REQ-028 Each channel SHALL hold one pending control word; a second queued word before transfer overwrites the first (latest wins); one BUSY-reply slot is shared.
REQ-029 Offer handshake: cmd/dataOut/phoneOut SHALL hold stable while cmd!=00 and transportBusy=1; transfer occurs on a cycle with cmd!=00 and transportBusy=0; next offer no earlier than the following cycle.
REQ-030 Offer priority: BUSY reply, then channel control words lowest index first, then audio.
REQ-031 audioInFlag SHALL pulse when at least one channel is CONNECTED and no audio fan-out is pending; the sample is then offered as cmd=10 to each CONNECTED channel's peer in index order, one transfer each.
REQ-032 Received audio from a CONNECTED peer SHALL update that channel's sample register; one cycle later audioOutFlag=1 and audioOut = signed sum of CONNECTED channels' registers, saturated to [-32768, 32767].
REQ-033 A channel leaving CONNECTED SHALL clear its sample register and drop its pending audio transfers.

Reset
REQ-034 While reset=0: all channels IDLE, peers 0, counters 0, pending words cleared; cmd=00, dataOut=0, phoneOut=0, audioOut=0, audioInFlag=0, audioOutFlag=0, sessionBusy=0; reset mid-handshake SHALL abandon the offer.

Verification
REQ-035 userInp=01, userCh=0, phoneNum=0x20 -> cmd=01, dataOut[7:0]=01, phoneOut=0x20; state0 1->2 on transfer.
REQ-036 From RING_OUT, cmdIn=01, packetIn=0x3002, srcIn=0x20 -> state0=4; audioInFlag pulses; audioIn=0x1234 offered with cmd=10 to 0x20.
REQ-037 Both channels CONNECTED, audio packets 0x7000 then 0x2000 from the two peers -> audioOut=0x7FFF (saturated).
REQ-038 Both channels non-IDLE, CALL_REQ from 0x55 -> cmd=01, dataOut[7:0]=03, phoneOut=0x55; states unchanged.
REQ-039 RING_OUT with no reply for RING_TO cycles -> HANGUP (04) offered to peer, state IDLE; transportBusy=1 for 5 cycles holds offer stable.

Source files
------------

// File: rtl/multi_session.sv
// Multi-channel call session controller: per-channel call FSMs, a single shared transmit
// offer port with a valid/busy handshake, audio fan-out to connected peers, and a saturating receive mix.
module multi_session #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 8,
  parameter int RING_TO = 1000,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   phoneNum,
  input  logic [4:0]          userInp,
  input  logic [CH_W-1:0]     userCh,
  input  logic [15:0]         audioIn,
  input  logic [1:0]          cmdIn,
  input  logic [15:0]         packetIn,
  input  logic [ADDR_W-1:0]   srcIn,
  input  logic                transportBusy,
  output logic                audioInFlag,
  output logic                audioOutFlag,
  output logic [15:0]         audioOut,
  output logic [1:0]          cmd,
  output logic [15:0]         dataOut,
  output logic [ADDR_W-1:0]   phoneOut,
  output logic                sessionBusy,
  output logic [3*N_CH-1:0]   current_state
);

  localparam int CNT_W = (RING_TO > 1) ? $clog2(RING_TO + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DIALING   = 3'd1,
    S_RING_OUT  = 3'd2,
    S_INCOMING  = 3'd3,
    S_CONNECTED = 3'd4
  } state_t;

  state_t             r_state      [N_CH];
  logic [ADDR_W-1:0]  r_peer       [N_CH];
  logic [CNT_W-1:0]   r_cnt        [N_CH];
  logic [7:0]         r_pend_code  [N_CH];
  logic [ADDR_W-1:0]  r_pend_dst   [N_CH];
  logic [15:0]        r_sample     [N_CH];
  logic [N_CH-1:0]    r_pend_v;
  logic [N_CH-1:0]    r_aud_pend;
  logic [15:0]        r_aud_sample;
  logic               r_busy_v;
  logic [ADDR_W-1:0]  r_busy_dst;
  logic [1:0]         r_cmd;
  logic [15:0]        r_data;
  logic [ADDR_W-1:0]  r_phone;
  logic               r_off_ctrl;
  logic [CH_W-1:0]    r_off_ch;
  logic               r_ain_flag;
  logic               r_aout_flag;
  logic [15:0]        r_aout;

  logic [N_CH-1:0]    w_match, w_conn, w_idle, w_pkt_hit, w_pkt_aud, w_user_ok, w_timeout;
  logic               w_call_req, w_ctrl_rx, w_aud_rx, w_xfer, w_aud_busy;
  logic               w_ctrl_any, w_aud_any, w_any_idle;
  logic [CH_W-1:0]    w_ctrl_ch, w_aud_ch, w_alloc_ch;
  logic signed [18:0] w_sum;
  logic [15:0]        w_s;
  logic [15:0]        w_mix;

  assign w_call_req = (cmdIn == 2'b01) && (packetIn[7:0] == 8'h01);
  assign w_ctrl_rx  = (cmdIn == 2'b01) && !w_call_req;
  assign w_aud_rx   = (cmdIn == 2'b10);
  assign w_xfer     = (r_cmd != 2'b00) && !transportBusy;
  assign w_aud_busy = (|(r_aud_pend & w_conn)) || (r_cmd == 2'b10);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_idle[gi]    = (r_state[gi] == S_IDLE);
      assign w_conn[gi]    = (r_state[gi] == S_CONNECTED);
      assign w_match[gi]   = !w_idle[gi] && (r_peer[gi] == srcIn);
      assign w_pkt_aud[gi] = w_aud_rx && w_match[gi] && w_conn[gi];
      // A packet claiming this channel suppresses any same-cycle user command on it.
      assign w_pkt_hit[gi] = (w_ctrl_rx && w_match[gi]) || w_pkt_aud[gi] ||
                             (w_call_req && w_any_idle && (w_alloc_ch == CH_W'(gi)));
      assign w_user_ok[gi] = (userCh == CH_W'(gi)) && !w_pkt_hit[gi];
      assign w_timeout[gi] = (r_state[gi] == S_RING_OUT) && (r_cnt[gi] == CNT_W'(RING_TO - 1));
      assign current_state[3*gi +: 3] = r_state[gi];
    end
  endgenerate

  // Priority encoders scan downward so the lowest index is the one left standing.
  always_comb begin
    w_ctrl_any = 1'b0;
    w_ctrl_ch  = '0;
    w_aud_any  = 1'b0;
    w_aud_ch   = '0;
    w_any_idle = 1'b0;
    w_alloc_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_pend_v[i]) begin
        w_ctrl_any = 1'b1;
        w_ctrl_ch  = CH_W'(i);
      end
      if (r_aud_pend[i] && w_conn[i]) begin
        w_aud_any = 1'b1;
        w_aud_ch  = CH_W'(i);
      end
      if (w_idle[i]) begin
        w_any_idle = 1'b1;
        w_alloc_ch = CH_W'(i);
      end
    end
  end

  // Mix uses the freshly received sample so the output reflects this cycle's packet.
  always_comb begin
    w_sum = '0;
    w_s   = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_s = w_pkt_aud[i] ? packetIn : r_sample[i];
      if (w_conn[i]) w_sum = w_sum + {{3{w_s[15]}}, w_s};
    end
    if (w_sum > 19'sd32767)       w_mix = 16'h7FFF;
    else if (w_sum < -19'sd32768) w_mix = 16'h8000;
    else                          w_mix = w_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i]     <= S_IDLE;
        r_peer[i]      <= '0;
        r_cnt[i]       <= '0;
        r_pend_code[i] <= '0;
        r_pend_dst[i]  <= '0;
        r_sample[i]    <= '0;
      end
      r_pend_v     <= '0;
      r_aud_pend   <= '0;
      r_aud_sample <= '0;
      r_busy_v     <= 1'b0;
      r_busy_dst   <= '0;
      r_cmd        <= 2'b00;
      r_data       <= '0;
      r_phone      <= '0;
      r_off_ctrl   <= 1'b0;
      r_off_ch     <= '0;
      r_ain_flag   <= 1'b0;
      r_aout_flag  <= 1'b0;
      r_aout       <= '0;
    end else begin
      if (w_xfer) begin
        r_cmd <= 2'b00;
        if (r_off_ctrl && (r_data[7:0] == 8'h01) && (r_state[r_off_ch] == S_DIALING))
          r_state[r_off_ch] <= S_RING_OUT;
      end else if (r_cmd == 2'b00) begin
        // Loading an offer consumes its slot, so a word queued later waits behind it.
        if (r_busy_v) begin
          r_cmd      <= 2'b01;
          r_data     <= 16'h0003;
          r_phone    <= r_busy_dst;
          r_busy_v   <= 1'b0;
          r_off_ctrl <= 1'b0;
        end else if (w_ctrl_any) begin
          r_cmd              <= 2'b01;
          r_data             <= {8'h00, r_pend_code[w_ctrl_ch]};
          r_phone            <= r_pend_dst[w_ctrl_ch];
          r_pend_v[w_ctrl_ch] <= 1'b0;
          r_off_ctrl         <= 1'b1;
          r_off_ch           <= w_ctrl_ch;
        end else if (w_aud_any) begin
          r_cmd                <= 2'b10;
          r_data               <= r_aud_sample;
          r_phone              <= r_peer[w_aud_ch];
          r_aud_pend[w_aud_ch] <= 1'b0;
          r_off_ctrl           <= 1'b0;
        end
      end

      r_ain_flag <= (|w_conn) && !w_aud_busy && !r_ain_flag;
      if (r_ain_flag) begin
        r_aud_sample <= audioIn;
        r_aud_pend   <= w_conn;
      end

      r_aout_flag <= |w_pkt_aud;
      if (|w_pkt_aud) r_aout <= w_mix;

      if (w_call_req && !w_any_idle) begin
        r_busy_v   <= 1'b1;
        r_busy_dst <= srcIn;
      end

      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= (r_state[i] == S_RING_OUT) ? r_cnt[i] + CNT_W'(1) : '0;
        if (!w_conn[i]) r_aud_pend[i] <= 1'b0;
        if (w_pkt_hit[i]) begin
          if (w_call_req) begin
            r_state[i] <= S_INCOMING;
            r_peer[i]  <= srcIn;
          end else if (w_aud_rx) begin
            r_sample[i] <= packetIn;
          end else if (packetIn[7:0] == 8'h04) begin
            r_state[i]  <= S_IDLE;
            r_sample[i] <= '0;
          end else if ((r_state[i] == S_RING_OUT) && (packetIn[7:0] == 8'h02)) begin
            r_state[i] <= S_CONNECTED;
          end else if ((r_state[i] == S_RING_OUT) && (packetIn[7:0] == 8'h03)) begin
            r_state[i] <= S_IDLE;
          end
        end else if (w_timeout[i]) begin
          r_state[i]     <= S_IDLE;
          r_pend_v[i]    <= 1'b1;
          r_pend_code[i] <= 8'h04;
          r_pend_dst[i]  <= r_peer[i];
        end else if (w_user_ok[i]) begin
          case (userInp)
            5'h01: if (w_idle[i]) begin
              r_state[i]     <= S_DIALING;
              r_peer[i]      <= phoneNum;
              r_pend_v[i]    <= 1'b1;
              r_pend_code[i] <= 8'h01;
              r_pend_dst[i]  <= phoneNum;
            end
            5'h02: if (r_state[i] == S_INCOMING) begin
              r_state[i]     <= S_CONNECTED;
              r_pend_v[i]    <= 1'b1;
              r_pend_code[i] <= 8'h02;
              r_pend_dst[i]  <= r_peer[i];
            end
            5'h03: if (!w_idle[i]) begin
              r_state[i]     <= S_IDLE;
              r_sample[i]    <= '0;
              r_pend_v[i]    <= 1'b1;
              r_pend_code[i] <= 8'h04;
              r_pend_dst[i]  <= r_peer[i];
            end
            5'h04: if (r_state[i] == S_INCOMING) begin
              r_state[i]     <= S_IDLE;
              r_pend_v[i]    <= 1'b1;
              r_pend_code[i] <= 8'h03;
              r_pend_dst[i]  <= r_peer[i];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign cmd          = r_cmd;
  assign dataOut      = r_data;
  assign phoneOut     = r_phone;
  assign audioInFlag  = r_ain_flag;
  assign audioOutFlag = r_aout_flag;
  assign audioOut     = r_aout;
  assign sessionBusy  = ~&w_idle;

endmodule

// File: tb/tb_multi_session.sv
// Directed bench for multi_session: call setup, answer, busy reply, audio mix, hangup, timeout, reset.
module tb_multi_session;
  localparam int N_CH = 2, ADDR_W = 8, RING_TO = 20;

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] phoneNum, srcIn, phoneOut;
  logic [4:0] userInp;
  logic [0:0] userCh;
  logic [15:0] audioIn, packetIn, audioOut, dataOut;
  logic [1:0] cmdIn, cmd;
  logic transportBusy, audioInFlag, audioOutFlag, sessionBusy;
  logic [3*N_CH-1:0] current_state;

  int checks = 0;
  int errors = 0;
  bit ok;

  multi_session #(.N_CH(N_CH), .ADDR_W(ADDR_W), .RING_TO(RING_TO)) dut (
    .clk(clk), .reset(reset), .phoneNum(phoneNum), .userInp(userInp), .userCh(userCh),
    .audioIn(audioIn), .cmdIn(cmdIn), .packetIn(packetIn), .srcIn(srcIn),
    .transportBusy(transportBusy), .audioInFlag(audioInFlag), .audioOutFlag(audioOutFlag),
    .audioOut(audioOut), .cmd(cmd), .dataOut(dataOut), .phoneOut(phoneOut),
    .sessionBusy(sessionBusy), .current_state(current_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    userInp = 5'h00;
    cmdIn   = 2'b00;
  endtask

  task automatic wait_cmd(input logic [1:0] c, output bit found);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (cmd === c) found = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; clr(); phoneNum = '0; userCh = '0; audioIn = 16'h1234;
    packetIn = '0; srcIn = '0; transportBusy = 1'b0;
    repeat (3) tick();
    checks++; if (cmd !== 2'b00) begin errors++; $display("FAIL reset_cmd got %h exp 0", cmd); end
    checks++; if (current_state !== 6'd0) begin errors++; $display("FAIL reset_state got %h exp 0", current_state); end
    checks++; if ({sessionBusy, audioInFlag, audioOutFlag} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {sessionBusy, audioInFlag, audioOutFlag}); end
    checks++; if ({audioOut, dataOut, phoneOut} !== 40'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {audioOut, dataOut, phoneOut}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_call;
    transportBusy = 1'b1;
    userInp = 5'h01; userCh = 1'b0; phoneNum = 8'h20;
    tick(); clr();
    checks++; if (current_state[2:0] !== 3'd1) begin errors++; $display("FAIL call_dialing got %0d exp 1", current_state[2:0]); end
    checks++; if (sessionBusy !== 1'b1) begin errors++; $display("FAIL call_busy got %b exp 1", sessionBusy); end
    tick();
    checks++; if ({cmd, dataOut[7:0], phoneOut} !== {2'b01, 8'h01, 8'h20}) begin errors++; $display("FAIL call_offer got %h/%h/%h exp 1/01/20", cmd, dataOut, phoneOut); end
    repeat (3) begin
      tick();
      checks++; if ({cmd, dataOut, phoneOut, current_state[2:0]} !== {2'b01, 16'h0001, 8'h20, 3'd1}) begin errors++; $display("FAIL call_hold got %h/%h/%h st %0d", cmd, dataOut, phoneOut, current_state[2:0]); end
    end
    transportBusy = 1'b0;
    tick();
    checks++; if ({cmd, current_state[2:0]} !== {2'b00, 3'd2}) begin errors++; $display("FAIL call_ringout got cmd %h st %0d exp 0/2", cmd, current_state[2:0]); end
  endtask

  task automatic test_accept;
    cmdIn = 2'b01; packetIn = 16'h3002; srcIn = 8'h20;
    tick(); clr();
    checks++; if (current_state[2:0] !== 3'd4) begin errors++; $display("FAIL accept_state got %0d exp 4", current_state[2:0]); end
    tick();
    checks++; if (audioInFlag !== 1'b1) begin errors++; $display("FAIL accept_ainflag got %b exp 1", audioInFlag); end
    wait_cmd(2'b10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL accept_audio_wait got none exp cmd 10"); end
    checks++; if ({dataOut, phoneOut} !== {16'h1234, 8'h20}) begin errors++; $display("FAIL accept_audio got %h/%h exp 1234/20", dataOut, phoneOut); end
  endtask

  task automatic test_mix;
    cmdIn = 2'b01; packetIn = 16'h0001; srcIn = 8'h30;
    tick(); clr();
    checks++; if (current_state !== {3'd3, 3'd4}) begin errors++; $display("FAIL mix_incoming got %o exp 34", current_state); end
    userInp = 5'h02; userCh = 1'b1;
    tick(); clr();
    checks++; if (current_state[5:3] !== 3'd4) begin errors++; $display("FAIL mix_answer got %0d exp 4", current_state[5:3]); end
    wait_cmd(2'b01, ok);
    checks++; if (!ok || {dataOut[7:0], phoneOut} !== {8'h02, 8'h30}) begin errors++; $display("FAIL mix_accept_tx got %b %h/%h exp 02/30", ok, dataOut, phoneOut); end
    cmdIn = 2'b10; packetIn = 16'h7000; srcIn = 8'h20;
    tick(); clr();
    checks++; if ({audioOutFlag, audioOut} !== {1'b1, 16'h7000}) begin errors++; $display("FAIL mix_first got %b/%h exp 1/7000", audioOutFlag, audioOut); end
    cmdIn = 2'b10; packetIn = 16'h2000; srcIn = 8'h30;
    tick(); clr();
    checks++; if ({audioOutFlag, audioOut} !== {1'b1, 16'h7FFF}) begin errors++; $display("FAIL mix_sat_pos got %b/%h exp 1/7fff", audioOutFlag, audioOut); end
    tick();
    checks++; if (audioOutFlag !== 1'b0) begin errors++; $display("FAIL mix_flag_pulse got %b exp 0", audioOutFlag); end
    cmdIn = 2'b10; packetIn = 16'h8000; srcIn = 8'h20;
    tick(); clr();
    checks++; if (audioOut !== 16'hA000) begin errors++; $display("FAIL mix_neg got %h exp a000", audioOut); end
    cmdIn = 2'b10; packetIn = 16'h8000; srcIn = 8'h30;
    tick(); clr();
    checks++; if (audioOut !== 16'h8000) begin errors++; $display("FAIL mix_sat_neg got %h exp 8000", audioOut); end
  endtask

  task automatic test_busy;
    cmdIn = 2'b01; packetIn = 16'h0001; srcIn = 8'h55;
    tick(); clr();
    checks++; if (current_state !== {3'd4, 3'd4}) begin errors++; $display("FAIL busy_states got %o exp 44", current_state); end
    wait_cmd(2'b01, ok);
    checks++; if (!ok || {dataOut[7:0], phoneOut} !== {8'h03, 8'h55}) begin errors++; $display("FAIL busy_reply got %b %h/%h exp 03/55", ok, dataOut, phoneOut); end
    cmdIn = 2'b01; packetIn = 16'h0004; srcIn = 8'h77;
    tick(); clr();
    checks++; if (current_state !== {3'd4, 3'd4}) begin errors++; $display("FAIL ignore_stranger got %o exp 44", current_state); end
    userInp = 5'h01; userCh = 1'b0; phoneNum = 8'h99;
    tick(); clr();
    checks++; if (current_state !== {3'd4, 3'd4}) begin errors++; $display("FAIL ignore_call got %o exp 44", current_state); end
  endtask

  task automatic test_hangup;
    userInp = 5'h03; userCh = 1'b1;
    tick(); clr();
    checks++; if (current_state[5:3] !== 3'd0) begin errors++; $display("FAIL hangup_user got %0d exp 0", current_state[5:3]); end
    wait_cmd(2'b01, ok);
    checks++; if (!ok || {dataOut[7:0], phoneOut} !== {8'h04, 8'h30}) begin errors++; $display("FAIL hangup_tx got %b %h/%h exp 04/30", ok, dataOut, phoneOut); end
    cmdIn = 2'b01; packetIn = 16'h0004; srcIn = 8'h20;
    tick(); clr();
    checks++; if ({current_state, sessionBusy} !== 7'd0) begin errors++; $display("FAIL hangup_peer got %o/%b exp 0/0", current_state, sessionBusy); end
    repeat (4) tick();
    checks++; if ({cmd, audioInFlag} !== 3'b000) begin errors++; $display("FAIL hangup_quiet got %h/%b exp 0/0", cmd, audioInFlag); end
  endtask

  task automatic test_conflict_reject;
    cmdIn = 2'b01; packetIn = 16'h0001; srcIn = 8'h60;
    tick(); clr();
    checks++; if (current_state[2:0] !== 3'd3) begin errors++; $display("FAIL conflict_incoming got %0d exp 3", current_state[2:0]); end
    cmdIn = 2'b01; packetIn = 16'h0004; srcIn = 8'h60; userInp = 5'h02; userCh = 1'b0;
    tick(); clr();
    checks++; if (current_state[2:0] !== 3'd0) begin errors++; $display("FAIL conflict_state got %0d exp 0", current_state[2:0]); end
    repeat (3) tick();
    checks++; if (cmd !== 2'b00) begin errors++; $display("FAIL conflict_no_accept got %h exp 0", cmd); end
    cmdIn = 2'b01; packetIn = 16'h0001; srcIn = 8'h60;
    tick(); clr();
    userInp = 5'h04; userCh = 1'b0;
    tick(); clr();
    checks++; if (current_state[2:0] !== 3'd0) begin errors++; $display("FAIL reject_state got %0d exp 0", current_state[2:0]); end
    wait_cmd(2'b01, ok);
    checks++; if (!ok || {dataOut[7:0], phoneOut} !== {8'h03, 8'h60}) begin errors++; $display("FAIL reject_tx got %b %h/%h exp 03/60", ok, dataOut, phoneOut); end
    tick();
  endtask

  task automatic test_timeout;
    transportBusy = 1'b0;
    userInp = 5'h01; userCh = 1'b0; phoneNum = 8'h40;
    tick(); clr();
    tick();
    checks++; if ({cmd, dataOut[7:0], phoneOut} !== {2'b01, 8'h01, 8'h40}) begin errors++; $display("FAIL to_callreq got %h/%h/%h exp 1/01/40", cmd, dataOut, phoneOut); end
    tick();
    checks++; if (current_state[2:0] !== 3'd2) begin errors++; $display("FAIL to_ringout got %0d exp 2", current_state[2:0]); end
    repeat (RING_TO - 1) tick();
    checks++; if (current_state[2:0] !== 3'd2) begin errors++; $display("FAIL to_early got %0d exp 2", current_state[2:0]); end
    tick();
    checks++; if ({cmd, current_state[2:0]} !== {2'b00, 3'd0}) begin errors++; $display("FAIL to_idle got cmd %h st %0d exp 0/0", cmd, current_state[2:0]); end
    transportBusy = 1'b1;
    tick();
    checks++; if ({cmd, dataOut, phoneOut} !== {2'b01, 16'h0004, 8'h40}) begin errors++; $display("FAIL to_hangup got %h/%h/%h exp 1/0004/40", cmd, dataOut, phoneOut); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if ({cmd, dataOut, phoneOut} !== {2'b01, 16'h0004, 8'h40}) begin errors++; $display("FAIL to_hold%0d got %h/%h/%h exp 1/0004/40", k, cmd, dataOut, phoneOut); end
    end
    transportBusy = 1'b0;
    tick();
    checks++; if (cmd !== 2'b00) begin errors++; $display("FAIL to_xfer got %h exp 0", cmd); end
  endtask

  task automatic test_reset_mid;
    transportBusy = 1'b1;
    userInp = 5'h01; userCh = 1'b1; phoneNum = 8'h21;
    tick(); clr();
    tick();
    checks++; if (cmd !== 2'b01) begin errors++; $display("FAIL rmid_offer got %h exp 1", cmd); end
    reset = 1'b0;
    #1;
    checks++; if ({cmd, current_state, sessionBusy} !== 9'd0) begin errors++; $display("FAIL rmid_async got %h/%o/%b exp 0", cmd, current_state, sessionBusy); end
    tick();
    reset = 1'b1;
    transportBusy = 1'b0;
    repeat (3) tick();
    checks++; if ({cmd, current_state} !== 8'd0) begin errors++; $display("FAIL rmid_abandon got %h/%o exp 0", cmd, current_state); end
  endtask

  initial begin
    test_reset();
    test_call();
    test_accept();
    test_mix();
    test_busy();
    test_hangup();
    test_conflict_reject();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
